vga_frame_capture: RTL and testbench
====================================

// Module: vga_frame_capture
// PURPOSE
//  Synthesizable VGA sink. Samples the gpu's hsync/vsync/bright/RGB stream on the pixel-clock enable.
//  Writes each visible pixel to a linear frame-buffer write port (addr = y*H_ACTIVE + x).
//  Checks line and frame geometry against the 640x480 timing and flags mismatches.
//  Sits beside the vga controller as an on-chip frame grabber and self-check for the gpu pipeline.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  V_ACTIVE  480  visible lines per frame
//  ADDR_W    19   frame-buffer address width; must satisfy 2**ADDR_W >= H_ACTIVE*V_ACTIVE
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-low
//  pix_en       in   1   pixel-clock enable (vga_clk_enable); inputs valid only when high
//  hsync        in   1   horizontal sync, active-low
//  vsync        in   1   vertical sync, active-low
//  bright       in   1   visible-region flag
//  R, G, B      in   8   pixel colour, each channel 8 bits
//  arm          in   1   one-cycle pulse; request capture of the next full frame
//  continuous   in   1   when 1, re-arm automatically after every frame
//  wr_en        out  1   frame-buffer write strobe, one clk wide
//  wr_addr      out  ADDR_W  write address
//  wr_data      out  24  {R,G,B}
//  busy         out  1   high in SYNC or CAPTURE
//  frame_done   out  1   one-clk pulse at end of a captured frame
//  line_err     out  1   sticky: some line had a visible length != H_ACTIVE
//  frame_err    out  1   sticky: visible line count != V_ACTIVE, or address overflow
//  lines_seen   out  10  visible lines counted in the last captured frame
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, x/y/addr counters 0, sample registers 0 with sync registers 1.
//  Sampling: on a clk edge with pix_en=1, hsync/vsync/bright/RGB load stage-1 registers; the previous values are kept for edge detection.
//   Nothing changes on edges where pix_en=0.
//  FSM:
//   IDLE    -> SYNC on arm=1.
//   SYNC    -> CAPTURE on a sampled vsync falling edge (1->0); clear x, y and addr.
//   CAPTURE -> DONE on the next sampled vsync falling edge.
//   DONE    lasts 1 clk; frame_done=1 and lines_seen<=y.
//            If y!=V_ACTIVE, frame_err<=1. Then -> SYNC if continuous=1, else -> IDLE.
//  arm is ignored outside IDLE. line_err/frame_err clear only on reset or on arm accepted in IDLE.
//  CAPTURE pixel path: a sampled pixel with bright=1 issues a write.
//   wr_en is high for the clk cycle after the sampling edge (latency 1 clk).
//   wr_addr=addr, wr_data={R,G,B}; then x++ and addr++.
//  Line end (sampled bright 1->0): if x!=H_ACTIVE, line_err<=1; x<=0; y++.
//  Overflow: a bright pixel when addr==H_ACTIVE*V_ACTIVE is not written and sets frame_err. addr saturates.
//  Simultaneous vsync falling edge and bright=1: vsync wins; the pixel is not written.
//   A pending partial line counts toward y and is length-checked.
//  hsync is used only for sanity: a sampled hsync falling edge while bright=1 sets line_err.
//  Reset mid-frame: async clear to IDLE. The partial frame is abandoned with no frame_done.
//   A new arm waits for a fresh vsync edge.
//  Widths: x 10b, y 10b, addr ADDR_W unsigned; no wrap, saturating counters.
// CONFIGURATION
//  VGA_CAPTURE_CRC_EN defined: adds output frame_crc[15:0].
//   CRC-16-CCITT (poly 0x1021, init 0xFFFF) over wr_data bytes R,G,B of each written pixel.
//   It is updated 3 bytes per write and latched on DONE.
//   The running CRC resets on entry to CAPTURE.
//  VGA_CAPTURE_CRC_EN undefined: port frame_crc and the CRC logic are absent; all else is identical.
// STRUCTURE
//  Shared package vga_pkg: H_ACTIVE/V_ACTIVE/H_TOTAL(800)/V_TOTAL(521) constants and the capture state encoding (IDLE, SYNC, CAPTURE, DONE).
//  One sub-module: crc16_rgb (24-bit-per-step CRC update); instantiated only under VGA_CAPTURE_CRC_EN.
// TESTING
//  1 Reset held low 100 ns with arm=1 -> all outputs 0, busy=0, no wr_en.
//  2 arm, then a full 640x480 frame from the vga controller, with constant RGB ff0000 and pix_en every 2nd clk:
//    -> 307200 wr_en pulses; last wr_addr=307199; frame_done once; lines_seen=480; no errors.
//  3 One line with 639 bright pixels -> line_err=1 after that line; frame_err=0; lines_seen=480.
//  4 Frame with 481 bright lines -> the 481st line's pixels are not written; frame_err=1; wr_addr stops at 307199.
//  5 continuous=1 over 2 frames -> 2 frame_done pulses, 614400 writes, busy stays high.
//    Async reset mid-frame 2 -> outputs 0 immediately, no third frame_done.
//  6 With VGA_CAPTURE_CRC_EN: a frame of all 000000 pixels -> frame_crc equals the golden model value.
//    Flipping one pixel to 000001 -> frame_crc differs.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and frame-capture state encoding.
// Used by vga_frame_capture; the optional CRC is enabled with VGA_CAPTURE_CRC_EN.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 521;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    // Geometry counters stick at all-ones instead of wrapping.
    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_frame_capture_if.sv
// Video input stream and frame-buffer write port of the VGA frame grabber.
// master = video source / memory side, slave = the capture block.
interface vga_frame_capture_if #(
    parameter int ADDR_W = 19
);
    logic              pix_en;
    logic              hsync;
    logic              vsync;
    logic              bright;
    logic [7:0]        R;
    logic [7:0]        G;
    logic [7:0]        B;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;

    modport master (
        output pix_en, hsync, vsync, bright, R, G, B,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  pix_en, hsync, vsync, bright, R, G, B,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/crc16_rgb.sv
// CRC-16-CCITT (poly 0x1021, MSB first) advanced by one RGB pixel: bytes R, G, B in order.
// Only compiled when VGA_CAPTURE_CRC_EN is defined.
`ifdef VGA_CAPTURE_CRC_EN
module crc16_rgb (
    input  logic [15:0] crc_i,
    input  logic [23:0] data_i,
    output logic [15:0] crc_o
);
    always_comb begin
        logic [15:0] c;
        c = crc_i;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ data_i[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                   c = {c[14:0], 1'b0};
        end
        crc_o = c;
    end
endmodule
`endif

// File: rtl/vga_frame_capture.sv
// VGA sink: grabs one (or every other, in continuous mode) frame into a linear frame buffer
// and checks line/frame geometry. Define VGA_CAPTURE_CRC_EN to add the frame_crc output.
module vga_frame_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int ADDR_W   = 19
) (
    input  logic               clk,
    input  logic               rst,
    vga_frame_capture_if.slave vid,
    input  logic               arm,
    input  logic               continuous,
    output logic               busy,
    output logic               frame_done,
    output logic               line_err,
    output logic               frame_err,
    output logic [9:0]         lines_seen
`ifdef VGA_CAPTURE_CRC_EN
    ,
    output logic [15:0]        frame_crc
`endif
);

    localparam logic [9:0]        H_LEN    = 10'(H_ACTIVE);
    localparam logic [9:0]        V_LEN    = 10'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(H_ACTIVE * V_ACTIVE);

    cap_state_e        state_q, state_d;
    logic              hs_q, hs_d, vs_q, vs_d, br_q, br_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [23:0]       wr_data_q, wr_data_d;
    logic              line_err_q, line_err_d, frame_err_q, frame_err_d;
    logic [9:0]        lines_seen_q, lines_seen_d;

    logic        vs_fall, br_fall, hs_fall;
    logic [23:0] pix_rgb;

    // Edges compare the incoming sample with the stage-1 copy, so a write issues on the sampling edge.
    assign vs_fall = vid.pix_en & vs_q & ~vid.vsync;
    assign br_fall = vid.pix_en & br_q & ~vid.bright;
    assign hs_fall = vid.pix_en & hs_q & ~vid.hsync;
    assign pix_rgb = {vid.R, vid.G, vid.B};

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crc_q, crc_d, crc_next, frame_crc_q, frame_crc_d;

    crc16_rgb u_crc (
        .crc_i  (crc_q),
        .data_i (pix_rgb),
        .crc_o  (crc_next)
    );
`endif

    always_comb begin
        state_d      = state_q;
        hs_d         = hs_q;
        vs_d         = vs_q;
        br_d         = br_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        line_err_d   = line_err_q;
        frame_err_d  = frame_err_q;
        lines_seen_d = lines_seen_q;
`ifdef VGA_CAPTURE_CRC_EN
        crc_d        = crc_q;
        frame_crc_d  = frame_crc_q;
`endif
        if (vid.pix_en) begin
            hs_d = vid.hsync;
            vs_d = vid.vsync;
            br_d = vid.bright;
        end

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d     = ST_SYNC;
                    line_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                end
            end
            ST_SYNC: begin
                if (vs_fall) begin
                    state_d = ST_CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
`ifdef VGA_CAPTURE_CRC_EN
                    crc_d   = 16'hFFFF;
`endif
                end
            end
            ST_CAPTURE: begin
                if (vs_fall) begin
                    // vsync wins over a coincident pixel; a line still in progress is closed here.
                    state_d = ST_DONE;
                    if (br_q) begin
                        y_d = sat_inc10(y_q);
                        if (x_q != H_LEN) line_err_d = 1'b1;
                    end
                end else if (vid.pix_en) begin
                    if (br_fall) begin
                        if (x_q != H_LEN) line_err_d = 1'b1;
                        x_d = '0;
                        y_d = sat_inc10(y_q);
                    end
                    if (vid.bright) begin
                        x_d = sat_inc10(x_q);
                        if (hs_fall) line_err_d = 1'b1;
                        if (addr_q == ADDR_END) begin
                            frame_err_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = pix_rgb;
                            addr_d    = addr_q + ADDR_W'(1);
`ifdef VGA_CAPTURE_CRC_EN
                            crc_d     = crc_next;
`endif
                        end
                    end
                end
            end
            default: begin
                lines_seen_d = y_q;
                if (y_q != V_LEN) frame_err_d = 1'b1;
`ifdef VGA_CAPTURE_CRC_EN
                frame_crc_d  = crc_q;
`endif
                state_d = continuous ? ST_SYNC : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            br_q         <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            lines_seen_q <= '0;
`ifdef VGA_CAPTURE_CRC_EN
            crc_q        <= 16'hFFFF;
            frame_crc_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            br_q         <= br_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
            lines_seen_q <= lines_seen_d;
`ifdef VGA_CAPTURE_CRC_EN
            crc_q        <= crc_d;
            frame_crc_q  <= frame_crc_d;
`endif
        end
    end

    assign vid.wr_en   = wr_en_q;
    assign vid.wr_addr = wr_addr_q;
    assign vid.wr_data = wr_data_q;
    assign busy        = (state_q == ST_SYNC) || (state_q == ST_CAPTURE);
    assign frame_done  = (state_q == ST_DONE);
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;
    assign lines_seen  = lines_seen_q;
`ifdef VGA_CAPTURE_CRC_EN
    assign frame_crc   = frame_crc_q;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a shrunken 16x8 raster (24x12 total), pix_en every 2nd clk.
// Frame scenarios come from a table plus random frames; writes are checked against a pixel-stream model.
module tb_vga_frame_capture;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int HT = 24;
    localparam int AW = 8;
    localparam int FB = H * V;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm;
    logic       continuous;
    logic       busy, frame_done, line_err, frame_err;
    logic [9:0] lines_seen;
`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] frame_crc;
`endif

    always #5 clk = ~clk;

    vga_frame_capture_if #(.ADDR_W(AW)) vif ();

    vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .vid        (vif),
        .arm        (arm),
        .continuous (continuous),
        .busy       (busy),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_err  (frame_err),
        .lines_seen (lines_seen)
`ifdef VGA_CAPTURE_CRC_EN
        ,
        .frame_crc  (frame_crc)
`endif
    );

    typedef struct {
        int nl;        // bright lines in the frame
        int sl;        // index of the odd-length line, -1 for none
        int slen;      // its length
        bit hsg;       // hsync glitch inside a bright run on line 2
        int mode;      // 0 ff0000, 1 random, 2 all zero, 3 zero with first pixel 000001
        bit exp_le;
        bit exp_fe;
        int exp_lines;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          fd_cnt = 0;
    int          fd_base = 0;
    bit          busy_watch = 1'b0;
    int          busy_drop = 0;

    int          m_addr, pix_no;
    bit          m_ovf, m_lerr;
    logic [15:0] m_crc;

    always @(negedge clk) begin
        if (vif.wr_en) got_q.push_back({vif.wr_addr, vif.wr_data});
        if (frame_done) fd_cnt++;
        if (busy_watch && !busy && !frame_done) busy_drop++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_bytes(input logic [15:0] crc, input logic [23:0] rgb);
        logic [15:0] c;
        c = crc;
        for (int b = 2; b >= 0; b--) begin
            c = c ^ {rgb[b*8 +: 8], 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic model_pixel(input logic [23:0] c);
        if (m_addr < FB) begin
            exp_q.push_back({8'(m_addr), c});
            m_crc = crc_bytes(m_crc, c);
            m_addr++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic pix(input bit hs, input bit vs, input bit br, input logic [23:0] c);
        @(posedge clk);
        #1;
        vif.hsync  = hs;
        vif.vsync  = vs;
        vif.bright = br;
        {vif.R, vif.G, vif.B} = c;
        vif.pix_en = 1'b1;
        @(posedge clk);
        #1;
        vif.pix_en = 1'b0;
    endtask

    task automatic emit_line(input bit vs, input int len, input bit hsg, input int mode, input bit cap);
        for (int p = 0; p < HT; p++) begin
            bit          br, hs;
            logic [23:0] c;
            br = (p < len);
            hs = !((p >= 18 && p < 21) || (hsg && p == 5));
            case (mode)
                0:       c = 24'hff0000;
                1:       c = 24'($urandom);
                2:       c = 24'h000000;
                default: c = (pix_no == 0) ? 24'h000001 : 24'h000000;
            endcase
            if (br) begin
                if (cap) model_pixel(c);
                pix_no++;
            end
            pix(hs, vs, br, c);
        end
        if (cap && len > 0 && (len != H || hsg)) m_lerr = 1'b1;
    endtask

    // vsync pulse, bright lines, then blanking up to 12 lines
    task automatic run_frame(input int nl, input int sl, input int slen, input bit hsg,
                             input int mode, input bit cap);
        if (cap) begin
            m_addr = 0;
            m_ovf  = 1'b0;
            m_lerr = 1'b0;
            m_crc  = 16'hFFFF;
        end
        pix_no = 0;
        emit_line(1'b0, 0, 1'b0, mode, 1'b0);
        emit_line(1'b0, 0, 1'b0, mode, 1'b0);
        for (int l = 0; l < nl; l++)
            emit_line(1'b1, (l == sl) ? slen : H, hsg && (l == 2), mode, cap);
        for (int l = 0; l < 10 - nl; l++)
            emit_line(1'b1, 0, 1'b0, mode, 1'b0);
    endtask

    task automatic close_frame();
        emit_line(1'b0, 0, 1'b0, 0, 1'b0);
        emit_line(1'b0, 0, 1'b0, 0, 1'b0);
        emit_line(1'b1, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_arm();
        @(posedge clk);
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
    endtask

    task automatic check_frame(input int exp_fd, input int exp_lines, input bit exp_le,
                               input bit exp_fe, input bit exp_busy);
        int n;
        chk("wr_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("wr_addr_data", got_q[i], exp_q[i]);
        chk("frame_done_count", fd_cnt - fd_base, exp_fd);
        chk("lines_seen", 32'(lines_seen), exp_lines);
        chk("line_err", line_err, exp_le);
        chk("frame_err", frame_err, exp_fe);
        chk("busy", busy, exp_busy);
`ifdef VGA_CAPTURE_CRC_EN
        chk("frame_crc", frame_crc, m_crc);
`endif
        got_q.delete();
        exp_q.delete();
        fd_base = fd_cnt;
    endtask

    initial begin
        vec_t        tbl[8];
        logic [15:0] crc_zero, crc_flip;
        int          nl, sl, slen;
        bit          hsg;

        tbl[0] = '{nl: 8, sl: -1, slen: 0,  hsg: 0, mode: 0, exp_le: 0, exp_fe: 0, exp_lines: 8};
        tbl[1] = '{nl: 8, sl: 3,  slen: 15, hsg: 0, mode: 1, exp_le: 1, exp_fe: 0, exp_lines: 8};
        tbl[2] = '{nl: 9, sl: -1, slen: 0,  hsg: 0, mode: 1, exp_le: 0, exp_fe: 1, exp_lines: 9};
        tbl[3] = '{nl: 7, sl: -1, slen: 0,  hsg: 0, mode: 1, exp_le: 0, exp_fe: 1, exp_lines: 7};
        tbl[4] = '{nl: 8, sl: 5,  slen: 17, hsg: 0, mode: 1, exp_le: 1, exp_fe: 1, exp_lines: 8};
        tbl[5] = '{nl: 8, sl: -1, slen: 0,  hsg: 1, mode: 1, exp_le: 1, exp_fe: 0, exp_lines: 8};
        tbl[6] = '{nl: 8, sl: -1, slen: 0,  hsg: 0, mode: 2, exp_le: 0, exp_fe: 0, exp_lines: 8};
        tbl[7] = '{nl: 8, sl: -1, slen: 0,  hsg: 0, mode: 3, exp_le: 0, exp_fe: 0, exp_lines: 8};
        crc_zero = '0;
        crc_flip = '0;

        vif.pix_en = 1'b0;
        vif.hsync  = 1'b1;
        vif.vsync  = 1'b1;
        vif.bright = 1'b0;
        vif.R = 8'h00; vif.G = 8'h00; vif.B = 8'h00;
        continuous = 1'b0;
        arm = 1'b1;
        rst = 1'b1;
        #1 rst = 1'b0;
        #100;
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_line_err", line_err, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_lines_seen", 32'(lines_seen), 0);
        chk("rst_wr_en", vif.wr_en, 1'b0);
        chk("rst_no_writes", got_q.size(), 0);
        arm = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_arm();
            run_frame(tbl[i].nl, tbl[i].sl, tbl[i].slen, tbl[i].hsg, tbl[i].mode, 1'b1);
            close_frame();
            if (i == 6) crc_zero = m_crc;
            if (i == 7) crc_flip = m_crc;
            check_frame(1, tbl[i].exp_lines, tbl[i].exp_le, tbl[i].exp_fe, 1'b0);
        end
`ifdef VGA_CAPTURE_CRC_EN
        n_vec++;
        if (crc_zero == crc_flip) begin
            n_bad++;
            $display("FAIL crc_flip_differs: got %0h expected not %0h", crc_flip, crc_zero);
        end
`endif

        for (int r = 0; r < 5; r++) begin
            nl   = $urandom_range(7, 9);
            sl   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nl - 1) : -1;
            slen = $urandom_range(12, 17);
            hsg  = ($urandom_range(0, 3) == 0);
            do_arm();
            run_frame(nl, sl, slen, hsg, 1, 1'b1);
            close_frame();
            check_frame(1, nl, m_lerr, (nl != V) || m_ovf, 1'b0);
        end

        // continuous: the frame after each frame_done is skipped while re-syncing
        continuous = 1'b1;
        do_arm();
        busy_watch = 1'b1;
        run_frame(8, -1, 0, 1'b0, 1, 1'b1);
        run_frame(8, -1, 0, 1'b0, 1, 1'b0);
        run_frame(8, -1, 0, 1'b0, 1, 1'b1);
        close_frame();
        busy_watch = 1'b0;
        chk("busy_hold", busy_drop, 0);
        check_frame(2, 8, 1'b0, 1'b0, 1'b1);
        continuous = 1'b0;

        // reset in the middle of a captured frame
        emit_line(1'b0, 0, 1'b0, 1, 1'b0);
        emit_line(1'b0, 0, 1'b0, 1, 1'b0);
        for (int l = 0; l < 3; l++) emit_line(1'b1, H, 1'b0, 1, 1'b0);
        chk("busy_mid_frame", busy, 1'b1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_wr_en", vif.wr_en, 1'b0);
        chk("midrst_frame_done", frame_done, 1'b0);
        chk("midrst_lines_seen", 32'(lines_seen), 0);
        got_q.delete();
        fd_base = fd_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int l = 0; l < 3; l++) emit_line(1'b1, H, 1'b0, 1, 1'b0);
        close_frame();
        chk("midrst_no_frame_done", fd_cnt - fd_base, 0);
        chk("midrst_no_writes", got_q.size(), 0);
        chk("midrst_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
